// File: rtl/neuron_mac_accumulator.sv
// Purpose: serial MAC producing one neuron pre-activation z = sum(x_i*w_i) + bias, signed Q4.4 saturated.
// Latency: z_valid rises one edge after FINISH is entered, i.e. two edges after the start of the cycle that carried the last pair.
// Backpressure: in_ready low outside ACCUM (in_valid low stalls ACCUM indefinitely); z_value/z_valid held until z_ready.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, bias        begin an evaluation (sampled only in IDLE), bias latched with it
//   x_in, w_in         operand pair, transferred on in_valid & in_ready
//   in_valid, in_ready input handshake
//   z_value, z_valid   saturated Q4.4 result and its valid, held until z_ready
//   z_ready            downstream accept
//   busy               high in every state except IDLE
module neuron_mac_accumulator #(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  // must be >= 2*DATA_W + clog2(N_INPUTS) + 1 so the running sum never wraps
  parameter int ACC_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] z_value,
  output logic              z_valid,
  input  logic              z_ready,
  output logic              busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = (N_INPUTS < 2) ? 1 : $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  // One extra bit over the accumulator so adding the scaled bias cannot wrap.
  typedef logic signed [ACC_W:0] sum_t;

  localparam sum_t Z_MAX = sum_t'((2 ** (DATA_W - 1)) - 1);
  localparam sum_t Z_MIN = sum_t'(-(2 ** (DATA_W - 1)));
  localparam logic [DATA_W-1:0] Z_MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Z_MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic [DATA_W-1:0]        bias_q;

  // Full-precision product: both operands widened first so the multiply is
  // done at product width (Q8.8), never truncated.
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign x_ext    = {{DATA_W{x_in[DATA_W-1]}}, x_in};
  assign w_ext    = {{DATA_W{w_in[DATA_W-1]}}, w_in};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Bias is Q4.4; shifting by FRAC_W aligns it with the Q8.8 accumulator.
  sum_t bias_shift;
  sum_t s_sum;
  sum_t r_shift;
  logic [DATA_W-1:0] z_sat;

  assign bias_shift = {{(ACC_W+1-DATA_W-FRAC_W){bias_q[DATA_W-1]}}, bias_q, {FRAC_W{1'b0}}};
  assign s_sum      = {acc[ACC_W-1], acc} + bias_shift;
  // Arithmetic shift floors toward -inf; no rounding term is added.
  assign r_shift    = s_sum >>> FRAC_W;

  always_comb begin
    z_sat = r_shift[DATA_W-1:0];
    if (r_shift > Z_MAX) begin
      z_sat = Z_MAX_D;
    end else if (r_shift < Z_MIN) begin
      z_sat = Z_MIN_D;
    end
  end

  logic xfer;
  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      bias_q   <= '0;
      z_value  <= '0;
      z_valid  <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bias_q   <= bias;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          if (xfer) begin
            acc <= acc + prod_ext;
            if (count == LAST_IDX) begin
              // Drop in_ready on the same edge so no extra pair slips in.
              in_ready <= 1'b0;
              count    <= '0;
              state    <= FINISH;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        FINISH: begin
          z_value <= z_sat;
          z_valid <= 1'b1;
          state   <= OUT;
        end

        OUT: begin
          // start is deliberately not looked at here; a start coinciding
          // with the z_ready handshake is lost and must be reissued in IDLE.
          if (z_ready) begin
            z_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          z_valid  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Purpose: directed self-checking bench for neuron_mac_accumulator.
// Latency: n/a (bench).
// Backpressure: exercises in_valid gaps and z_ready hold-off.
module tb_neuron_mac_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] bias;
  logic [7:0] x_in;
  logic [7:0] w_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] z_value;
  logic       z_valid;
  logic       z_ready;
  logic       busy;

  int checks;
  int errors;
  int hs_count;

  neuron_mac_accumulator #(
    .N_INPUTS(2),
    .DATA_W  (8),
    .FRAC_W  (4),
    .ACC_W   (18)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bias    (bias),
    .x_in    (x_in),
    .w_in    (w_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .z_value (z_value),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output handshakes seen by the downstream block.
  always @(posedge clk or posedge rst) begin
    if (rst) hs_count <= 0;
    else if (z_valid && z_ready) hs_count <= hs_count + 1;
  end

  // Present start for exactly one rising edge; returns just after that edge.
  task automatic start_eval(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait `gap` idle cycles, then offer a pair until accepted (bounded).
  // Returns at the negedge just after the accepting edge.
  task automatic send_pair(input logic [7:0] x, input logic [7:0] w, input int gap, output bit ok);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    x_in = x;
    w_in = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full evaluation with z_ready asserted as soon as z_valid is seen.
  task automatic run_neuron(input logic [7:0] b, input logic [7:0] x0, input logic [7:0] w0,
                            input logic [7:0] x1, input logic [7:0] w1,
                            output logic [7:0] z, output bit ok);
    bit a0, a1;
    int t;
    start_eval(b);
    send_pair(x0, w0, 0, a0);
    send_pair(x1, w1, 0, a1);
    t = 0;
    while (!z_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = a0 && a1 && z_valid;
    z = z_value;
    z_ready = 1'b1;
    @(negedge clk);
    z_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (z_value !== 8'h00) begin errors++; $display("FAIL reset_z_value got %h want 00", z_value); end
    if (z_valid !== 1'b0)  begin errors++; $display("FAIL reset_z_valid got %b want 0", z_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Scenario 1 stepped by hand to pin down the cycle-level timing.
  task automatic test_xor;
    bit a0, a1;
    int hs0;
    start_eval(8'hF0);
    checks += 2;
    if (busy !== 1'b1)     begin errors++; $display("FAIL xor_busy_after_start got %b want 1", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL xor_in_ready_accum got %b want 1", in_ready); end
    send_pair(8'h10, 8'h10, 0, a0);
    send_pair(8'h10, 8'h10, 0, a1);
    // Now half a cycle after the edge that took the last pair: FINISH.
    checks += 3;
    if (!(a0 && a1))       begin errors++; $display("FAIL xor_pairs_accepted got %b%b want 11", a0, a1); end
    if (z_valid !== 1'b0)  begin errors++; $display("FAIL xor_z_valid_in_finish got %b want 0", z_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL xor_in_ready_finish got %b want 0", in_ready); end
    @(negedge clk);
    checks += 2;
    if (z_valid !== 1'b1)  begin errors++; $display("FAIL xor_z_valid_latency got %b want 1", z_valid); end
    if (z_value !== 8'h10) begin errors++; $display("FAIL xor_z_value got %h want 10", z_value); end
    hs0 = hs_count;
    z_ready = 1'b1;
    @(negedge clk);
    z_ready = 1'b0;
    checks += 4;
    if (z_valid !== 1'b0)     begin errors++; $display("FAIL xor_z_valid_after_hs got %b want 0", z_valid); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL xor_busy_after_hs got %b want 0", busy); end
    if (z_value !== 8'h10)    begin errors++; $display("FAIL xor_z_value_kept got %h want 10", z_value); end
    if (hs_count !== hs0 + 1) begin errors++; $display("FAIL xor_handshakes got %0d want %0d", hs_count - hs0, 1); end
  endtask

  task automatic test_saturation;
    logic [7:0] z;
    bit ok;
    // 2 * (127*127) = 32258 Q8.8 -> 2016 Q4.4 -> clamp 0x7F
    run_neuron(8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, z, ok);
    checks++;
    if (!ok || z !== 8'h7F) begin errors++; $display("FAIL pos_sat got %h ok=%b want 7F", z, ok); end
    // 2 * (-128*127) - 2048 = -34560 -> -2160 -> clamp 0x80
    run_neuron(8'h80, 8'h80, 8'h7F, 8'h80, 8'h7F, z, ok);
    checks++;
    if (!ok || z !== 8'h80) begin errors++; $display("FAIL neg_sat got %h ok=%b want 80", z, ok); end
  endtask

  task automatic test_floor;
    logic [7:0] z;
    bit ok;
    // +2 LSB of Q8.8 floors to 0
    run_neuron(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, z, ok);
    checks++;
    if (!ok || z !== 8'h00) begin errors++; $display("FAIL floor_pos got %h ok=%b want 00", z, ok); end
    // -2 LSB of Q8.8 floors to -1
    run_neuron(8'h00, 8'hFF, 8'h01, 8'hFF, 8'h01, z, ok);
    checks++;
    if (!ok || z !== 8'hFF) begin errors++; $display("FAIL floor_neg got %h ok=%b want FF", z, ok); end
  endtask

  task automatic test_backpressure;
    bit a0, a1;
    int t;
    int hs0;
    int bad;
    start_eval(8'hF0);
    send_pair(8'h10, 8'h10, 3, a0);
    send_pair(8'h10, 8'h10, 3, a1);
    t = 0;
    while (!z_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!(a0 && a1 && z_valid)) begin errors++; $display("FAIL bp_result_arrives got ok=%b%b%b want 111", a0, a1, z_valid); end
    hs0 = hs_count;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (z_valid !== 1'b1 || z_value !== 8'h10 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold %0d of 5 cycles not holding 10/1 (last %h/%b)", bad, z_value, z_valid); end
    // start alongside the handshake must be ignored.
    z_ready = 1'b1;
    start   = 1'b1;
    bias    = 8'h00;
    @(negedge clk);
    z_ready = 1'b0;
    start   = 1'b0;
    checks += 3;
    if (hs_count !== hs0 + 1) begin errors++; $display("FAIL bp_handshakes got %0d want 1", hs_count - hs0); end
    if (z_valid !== 1'b0)     begin errors++; $display("FAIL bp_z_valid_after got %b want 0", z_valid); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL bp_start_ignored busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    checks++;
    if (hs_count !== hs0 + 1) begin errors++; $display("FAIL bp_extra_handshake got %0d want 1", hs_count - hs0); end
  endtask

  task automatic test_reset_mid;
    bit a0;
    logic [7:0] z;
    bit ok;
    start_eval(8'h70);
    send_pair(8'h7F, 8'h7F, 0, a0);
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (z_value !== 8'h00) begin errors++; $display("FAIL midrst_z_value got %h want 00", z_value); end
    if (z_valid !== 1'b0)  begin errors++; $display("FAIL midrst_z_valid got %b want 0", z_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (z_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output got %b want 0", z_valid); end
    run_neuron(8'hF0, 8'h10, 8'h10, 8'h10, 8'h10, z, ok);
    checks++;
    if (!ok || z !== 8'h10) begin errors++; $display("FAIL midrst_next_result got %h ok=%b want 10", z, ok); end
  endtask

  // Two evaluations with no idle gap between them.
  task automatic test_back_to_back;
    logic [7:0] z;
    bit ok;
    run_neuron(8'h10, 8'h20, 8'h08, 8'hE0, 8'h08, z, ok);  // 1.0 + 2*0.5 - 2*0.5 = 1.0
    checks++;
    if (!ok || z !== 8'h10) begin errors++; $display("FAIL b2b_first got %h ok=%b want 10", z, ok); end
    run_neuron(8'hF8, 8'h18, 8'h10, 8'h08, 8'hF0, z, ok);  // -0.5 + 1.5 - 0.5 = 0.5
    checks++;
    if (!ok || z !== 8'h08) begin errors++; $display("FAIL b2b_second got %h ok=%b want 08", z, ok); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bias     = 8'h00;
    x_in     = 8'h00;
    w_in     = 8'h00;
    in_valid = 1'b0;
    z_ready  = 1'b0;

    test_reset;
    test_xor;
    test_saturation;
    test_floor;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a task wedges despite its bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
